fir_psum_drain: RTL and testbench

Result drain at the tail of the systolic FIR chain of PEs. It tracks which partial sums leaving the last PE are real outputs, discards the warm-up results, and buffers the rest in a FIFO. Results leave through a valid/ready handshake to the downstream consumer. It is the reading end of the chain that the input feeder writes into.

---
 rtl/fir_psum_drain_pkg.sv | 9 +
 rtl/fir_psum_drain_fifo.sv | 83 ++++++++
 rtl/fir_psum_drain.sv | 94 +++++++++
 tb/tb_fir_psum_drain.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_psum_drain_pkg.sv
// Shared definitions for the systolic FIR chain: data widths and the
// default chain length used by both the PE chain and the result drain.
package fir_psum_drain_pkg;

    localparam int PSUM_W       = 16;  // partial-sum width leaving each PE
    localparam int ELEM_W       = 8;   // sample element width entering the chain
    localparam int TAPS_DEFAULT = 4;   // PEs in the chain, equal to its latency

endpackage

// File: rtl/fir_psum_drain_fifo.sv
// psum_fifo: first-word-fall-through synchronous FIFO for chain results.
// Ports:
//   clk, clear        clock, asynchronous active-high reset
//   flush             synchronous restart; push/pop in that cycle are ignored
//   push, din         write request and data (accepted when not full or popping)
//   pop               read request (ignored when empty)
//   dout              head entry, 0 while empty
//   full, empty       occupancy flags
//   count             registered occupancy
//   almost_full       registered count >= AF_LEVEL
module psum_fifo #(
    parameter int W        = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   count_next;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count       <= count_next;
            almost_full <= (count_next >= AF_CNT);
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fir_psum_drain.sv
// fir_psum_drain: result drain at the tail of the systolic FIR chain.
// Tracks which partial sums leaving the last PE are real, discards the
// TAPS-1 warm-up results, and buffers the rest for a valid/ready consumer.
// Ports:
//   clk, clear        clock, asynchronous active-high reset
//   sample_valid      feeder drove a real sample into the first PE this cycle
//   pSum_in           pSum_out of the last PE
//   flush             synchronous restart, single cycle
//   out_data          head result, out_valid marks it valid
//   out_ready         consumer accepts the head result
//   count             FIFO occupancy (registered)
//   almost_full       count >= AF_LEVEL (registered); feeder must stall
//   overflow          sticky: a result was dropped
module fir_psum_drain
    import fir_psum_drain_pkg::*;
#(
    parameter int TAPS     = TAPS_DEFAULT,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic [PSUM_W-1:0]        pSum_in,
    input  logic                     flush,
    output logic [PSUM_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int SW = $clog2(TAPS) + 1;
    localparam logic [SW-1:0] SKIP_INIT = SW'(TAPS - 1);
    localparam logic [SW-1:0] SKIP_ONE  = SW'(1);

    logic [TAPS-1:0] vpipe;
    logic [TAPS-1:0] vpipe_next;
    logic [SW-1:0]   skip_cnt;
    logic            arrive;
    logic            skipping;
    logic            wr_req;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    // vpipe mirrors the chain latency so vpipe[TAPS-1] lines up with pSum_in.
    always_comb begin
        vpipe_next    = vpipe << 1;
        vpipe_next[0] = sample_valid;
    end

    assign arrive    = vpipe[TAPS-1];
    assign skipping  = (skip_cnt != '0);
    assign wr_req    = arrive && !skipping;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            vpipe    <= '0;
            skip_cnt <= SKIP_INIT;
            overflow <= 1'b0;
        end else if (flush) begin
            vpipe    <= '0;
            skip_cnt <= SKIP_INIT;
            overflow <= 1'b0;
        end else begin
            vpipe <= vpipe_next;
            if (arrive && skipping) skip_cnt <= skip_cnt - SKIP_ONE;
            if (wr_req && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    psum_fifo #(
        .W        (PSUM_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
        .clk         (clk),
        .clear       (clear),
        .flush       (flush),
        .push        (wr_req),
        .pop         (pop),
        .din         (pSum_in),
        .dout        (out_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (almost_full),
        .count       (count)
    );

endmodule

// File: tb/tb_fir_psum_drain.sv
module tb_fir_psum_drain;
    import fir_psum_drain_pkg::*;

    localparam int TAPS     = 4;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int VW       = 1 + 16 + CW + 1 + 1;

    logic          clk = 1'b0;
    logic          clear;
    logic          sample_valid;
    logic [15:0]   pSum_in;
    logic          flush;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          overflow;

    fir_psum_drain #(
        .TAPS     (TAPS),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .sample_valid (sample_valid),
        .pSum_in      (pSum_in),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model: queue of stored results, arrival schedule by edge number.
    int mq[$];
    int skip_m;
    bit ovf_m;
    bit due[int];
    int feed_vals[$];
    int got[$];

    logic [VW-1:0] obs;
    logic [VW-1:0] exp_vec;
    assign obs = {out_valid, out_data, count, almost_full, overflow};

    function automatic void model_reset();
        mq.delete();
        ovf_m  = 1'b0;
        skip_m = TAPS - 1;
        due.delete();
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [15:0] d;
        d = (mq.size() > 0) ? 16'(mq[0]) : 16'h0;
        return {mq.size() > 0, d, CW'(mq.size()), mq.size() >= AF_LEVEL, ovf_m};
    endfunction

    // Drive one cycle, advance the model across the edge, sample #1 after it.
    task automatic tick(input bit sv, input bit rdy, input bit fl);
        int  e;
        bit  arr;
        int  v;
        e   = edge_n + 1;
        arr = due.exists(e);
        if (arr) due.delete(e);
        if (arr && !fl && feed_vals.size() > 0) v = feed_vals.pop_front();
        else v = int'($urandom_range(0, 65535));
        sample_valid = sv;
        out_ready    = rdy;
        flush        = fl;
        pSum_in      = 16'(v);
        if (out_valid && rdy && !fl) got.push_back(int'(out_data));
        if (fl) begin
            model_reset();
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (arr) begin
                if (skip_m > 0) skip_m--;
                else if (mq.size() == DEPTH) ovf_m = 1'b1;
                else mq.push_back(v);
            end
            if (sv) due[e + TAPS] = 1'b1;
        end
        @(posedge clk);
        edge_n++;
        #1;
        exp_vec = model_vec();
    endtask

    task automatic test_reset();
        clear = 1'b1; sample_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; pSum_in = '0;
        model_reset();
        #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_async got=%h want=%h", obs, {VW{1'b0}});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_hold got=%h want=%h", obs, {VW{1'b0}});
        end
        clear = 1'b0;
        exp_vec = '0;
    endtask

    task automatic test_warmup();
        int e0, first;
        int exp_q[$];
        exp_q = '{13, 14, 15};
        feed_vals = '{10, 11, 12, 13, 14, 15};
        got.delete();
        first = -1;
        e0 = edge_n + 1;
        for (int i = 0; i < 16; i++) begin
            tick(i < 6, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL warmup_cycle edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
            if (out_valid && first < 0) first = edge_n;
        end
        total++;
        if (first != e0 + TAPS + TAPS - 1) begin
            bad++; $display("FAIL warmup_latency got=%0d want=%0d", first - e0, 2*TAPS - 1);
        end
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL warmup_count got=%0d want=%0d", got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got[i] != exp_q[i]) begin
                    bad++; $display("FAIL warmup_data idx=%0d got=%0d want=%0d", i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit af_seen;
        af_seen = 1'b0;
        feed_vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        got.delete();
        for (int i = 0; i < 9 + TAPS + 1; i++) begin
            tick(i < 9, 1'b0, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL bp_cycle edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
            if (almost_full && !af_seen) begin
                af_seen = 1'b1;
                total++;
                if (count !== CW'(AF_LEVEL)) begin
                    bad++; $display("FAIL bp_af_level got=%0d want=%0d", count, AF_LEVEL);
                end
            end
        end
        total++;
        if (count !== CW'(DEPTH) || overflow !== 1'b1 || !af_seen) begin
            bad++; $display("FAIL bp_full got count=%0d ovf=%b af_seen=%b want count=%0d ovf=1 af_seen=1",
                            count, overflow, af_seen, DEPTH);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL bp_drain_cycle edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        total++;
        if (got.size() != DEPTH) begin
            bad++; $display("FAIL bp_drain_count got=%0d want=%0d", got.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (got[i] != i + 1) begin
                    bad++; $display("FAIL bp_drain_data idx=%0d got=%0d want=%0d", i, got[i], i + 1);
                end
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL bp_ovf_sticky got=%b want=1", overflow);
        end
    endtask

    task automatic test_full_pushpop();
        tick(1'b0, 1'b0, 1'b1);
        total++;
        if (obs !== exp_vec) begin
            bad++; $display("FAIL fpp_flush got=%h want=%h", obs, exp_vec);
        end
        feed_vals = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 11 + TAPS + 1; i++) begin
            tick(i < 11, 1'b0, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL fpp_fill edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        feed_vals = '{99};
        tick(1'b1, 1'b0, 1'b0);
        // Keep ready low until the arrival edge, then pop on exactly that edge.
        for (int i = 0; i < TAPS + 2 && due.num() > 0; i++) begin
            tick(1'b0, due.exists(edge_n + 1), 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL fpp_cycle edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        total++;
        if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
            bad++; $display("FAIL fpp_count got count=%0d ovf=%b want count=%0d ovf=0", count, overflow, DEPTH);
        end
        got.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL fpp_drain edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        total++;
        if (got.size() != DEPTH || got[0] != 2 || got[DEPTH-1] != 99) begin
            bad++; $display("FAIL fpp_order got size=%0d first=%0d last=%0d want size=%0d first=2 last=99",
                            got.size(), (got.size() > 0) ? got[0] : -1,
                            (got.size() > 0) ? got[got.size()-1] : -1, DEPTH);
        end
    endtask

    task automatic test_pointer_wrap();
        int sent[$];
        for (int i = 0; i < 20; i++) sent.push_back(int'($urandom_range(0, 65535)));
        feed_vals = sent;
        got.delete();
        for (int i = 0; i < 60; i++) begin
            tick((i < 40) && (i % 2 == 0), (i % 2 == 1), 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL wrap_cycle edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        total++;
        if (got.size() != 20 || overflow !== 1'b0) begin
            bad++; $display("FAIL wrap_count got=%0d ovf=%b want=20 ovf=0", got.size(), overflow);
        end else begin
            for (int i = 0; i < 20; i++) begin
                total++;
                if (got[i] != sent[i]) begin
                    bad++; $display("FAIL wrap_data idx=%0d got=%0d want=%0d", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        tick(1'b0, 1'b0, 1'b1);
        feed_vals = '{0, 0, 0, 5, 6, 7, 8, 9, 77, 78};
        for (int i = 0; i < 12; i++) tick(i < 8, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        total++;
        if (count !== CW'(5) || due.num() != 2) begin
            bad++; $display("FAIL flush_pre got count=%0d inflight=%0d want 5 and 2", count, due.num());
        end
        tick(1'b0, 1'b0, 1'b1);
        total++;
        if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || obs !== exp_vec) begin
            bad++; $display("FAIL flush_clears got=%h want=%h", obs, exp_vec);
        end
        feed_vals = '{256, 257, 258, 259, 260};
        got.delete();
        for (int i = 0; i < 16; i++) begin
            tick(i < 5, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL flush_after edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        total++;
        if (got.size() != 2 || got[0] != 259 || got[1] != 260) begin
            bad++; $display("FAIL flush_rediscard got size=%0d want size=2 values 259,260", got.size());
        end
    endtask

    task automatic test_async_reset();
        feed_vals = '{40, 41};
        for (int i = 0; i < TAPS + 3; i++) tick(i < 2, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'd40) begin
            bad++; $display("FAIL arst_pre got v=%b d=%0d want v=1 d=40", out_valid, out_data);
        end
        #3;
        clear = 1'b1;
        #1;
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL arst_immediate got=%h want=%h", obs, {VW{1'b0}});
        end
        model_reset();
        exp_vec = '0;
        #1;
        clear = 1'b0;
        feed_vals = '{512, 513, 514, 515, 516};
        got.delete();
        for (int i = 0; i < 16; i++) begin
            tick(i < 5, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL arst_after edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
        total++;
        if (got.size() != 2 || got[0] != 515 || got[1] != 516) begin
            bad++; $display("FAIL arst_rediscard got size=%0d want size=2 values 515,516", got.size());
        end
    endtask

    task automatic test_random();
        bit sv;
        feed_vals.delete();
        for (int i = 0; i < 300; i++) begin
            sv = (mq.size() + due.num() < DEPTH) && ($urandom_range(0, 1) == 1);
            tick(sv, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
            total++;
            if (obs !== exp_vec) begin
                bad++; $display("FAIL random_cycle edge=%0d got=%h want=%h", edge_n, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_backpressure();
        test_full_pushpop();
        test_pointer_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
